// File: rtl/mem_access_unit.sv
// MEM stage with internal data memory, byte/half/word stores, extended loads, misalignment trap and MEM/WB register.
// Latency 1 except aligned loads (RD_LAT); o_stall holds upstream while a multi-cycle load is outstanding.
module mem_access_unit #(
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [31:0]       i_alu_result,
    input  logic [31:0]       i_store_data,
    input  logic              i_mem_write,
    input  logic              i_mem_read,
    input  logic [1:0]        i_bhw,
    input  logic              i_unsigned,
    input  logic [ADDR_W-1:0] i_debug_addr,
    output logic [31:0]       o_debug_mem,
    output logic              o_stall,
    output logic              o_valid,
    output logic [31:0]       o_alu_result,
    output logic [31:0]       o_read_data,
    output logic              o_misaligned
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [2:0] LAST_CNT = 3'(RD_LAT - 1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;
    logic [31:0] lword_q, lword_d;
    logic [1:0]  loff_q, loff_d;
    logic [1:0]  lbhw_q, lbhw_d;
    logic        luns_q, luns_d;

    logic [31:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] widx;
    logic [1:0]        off;
    logic              is_store, is_load, size_half, size_word, misaligned, mem_wen;
    logic [31:0]       mem_word, wr_word;

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] ofs,
                                                input logic [1:0] bhw, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{ofs, 3'b000} +: 8];
        h = word[{ofs[1], 4'b0000} +: 16];
        case (bhw)
            2'b00:   extend_load = {{24{b[7] & ~uns}}, b};
            2'b01:   extend_load = {{16{h[15] & ~uns}}, h};
            default: extend_load = word;
        endcase
    endfunction

    assign widx      = i_alu_result[ADDR_W+1:2];
    assign off       = i_alu_result[1:0];
    assign is_store  = i_mem_write;
    assign is_load   = i_mem_read & ~i_mem_write;
    assign size_half = (i_bhw == 2'b01);
    assign size_word = i_bhw[1];
    assign misaligned = (is_store | is_load) &
                        ((size_half & off[0]) | (size_word & (off != 2'b00)));
    assign mem_word  = mem_q[widx];

    // Merge store lanes into the current word so untouched lanes keep their value.
    always_comb begin
        wr_word = mem_word;
        case (i_bhw)
            2'b00:   wr_word[{off, 3'b000} +: 8]     = i_store_data[7:0];
            2'b01:   wr_word[{off[1], 4'b0000} +: 16] = i_store_data[15:0];
            default: wr_word = i_store_data;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        alu_d   = alu_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        lword_d = lword_q;
        loff_d  = loff_q;
        lbhw_d  = lbhw_q;
        luns_d  = luns_q;
        mem_wen = 1'b0;
        o_stall = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    if (is_load && !misaligned && (RD_LAT > 1)) begin
                        o_stall = 1'b1;
                        state_d = ST_WAIT;
                        cnt_d   = 3'd1;
                        lword_d = mem_word;
                        loff_d  = off;
                        lbhw_d  = i_bhw;
                        luns_d  = i_unsigned;
                    end else begin
                        valid_d = 1'b1;
                        alu_d   = i_alu_result;
                        mis_d   = misaligned;
                        rdata_d = (is_load && !misaligned) ?
                                  extend_load(mem_word, off, i_bhw, i_unsigned) : 32'd0;
                        mem_wen = is_store && !misaligned;
                    end
                end
            end
            ST_WAIT: begin
                // Upstream is released on the last wait cycle so the next op lines up with o_valid.
                if (cnt_q == LAST_CNT) begin
                    valid_d = 1'b1;
                    alu_d   = i_alu_result;
                    mis_d   = 1'b0;
                    rdata_d = extend_load(lword_q, loff_q, lbhw_q, luns_q);
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    o_stall = 1'b1;
                    cnt_d   = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            valid_q <= 1'b0;
            alu_q   <= 32'd0;
            rdata_q <= 32'd0;
            mis_q   <= 1'b0;
            lword_q <= 32'd0;
            loff_q  <= 2'd0;
            lbhw_q  <= 2'd0;
            luns_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            alu_q   <= alu_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            lword_q <= lword_d;
            loff_q  <= loff_d;
            lbhw_q  <= lbhw_d;
            luns_q  <= luns_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_wen) begin
            mem_q[widx] <= wr_word;
        end
    end

    assign o_debug_mem  = mem_q[i_debug_addr];
    assign o_valid      = valid_q;
    assign o_alu_result = alu_q;
    assign o_read_data  = rdata_q;
    assign o_misaligned = mis_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: three instances (RD_LAT 1, 3, 4) against a byte-level memory model.
module tb_mem_access_unit;
    localparam int ND = 3;

    logic clk;
    logic rst;
    logic [31:0] i_addr, i_sdata;
    logic i_wr, i_rd, i_uns;
    logic [1:0] i_bz;
    logic [4:0] dbg_addr;

    logic [ND-1:0]       vld, stall, ov, omis;
    logic [ND-1:0][31:0] oalu, ordata, dbg_o;

    logic [31:0] mdl [ND][32];

    int tests_run = 0;
    int tests_failed = 0;

    int lat_o, stc, ev, el;
    logic vo, mo, em;
    logic [31:0] ao, ro, er;

    mem_access_unit #(.ADDR_W(5), .RD_LAT(1)) u_l1 (
        .i_clk(clk), .i_reset(rst), .i_valid(vld[0]), .i_alu_result(i_addr), .i_store_data(i_sdata),
        .i_mem_write(i_wr), .i_mem_read(i_rd), .i_bhw(i_bz), .i_unsigned(i_uns), .i_debug_addr(dbg_addr),
        .o_debug_mem(dbg_o[0]), .o_stall(stall[0]), .o_valid(ov[0]), .o_alu_result(oalu[0]),
        .o_read_data(ordata[0]), .o_misaligned(omis[0]));
    mem_access_unit #(.ADDR_W(5), .RD_LAT(3)) u_l3 (
        .i_clk(clk), .i_reset(rst), .i_valid(vld[1]), .i_alu_result(i_addr), .i_store_data(i_sdata),
        .i_mem_write(i_wr), .i_mem_read(i_rd), .i_bhw(i_bz), .i_unsigned(i_uns), .i_debug_addr(dbg_addr),
        .o_debug_mem(dbg_o[1]), .o_stall(stall[1]), .o_valid(ov[1]), .o_alu_result(oalu[1]),
        .o_read_data(ordata[1]), .o_misaligned(omis[1]));
    mem_access_unit #(.ADDR_W(5), .RD_LAT(4)) u_l4 (
        .i_clk(clk), .i_reset(rst), .i_valid(vld[2]), .i_alu_result(i_addr), .i_store_data(i_sdata),
        .i_mem_write(i_wr), .i_mem_read(i_rd), .i_bhw(i_bz), .i_unsigned(i_uns), .i_debug_addr(dbg_addr),
        .o_debug_mem(dbg_o[2]), .o_stall(stall[2]), .o_valid(ov[2]), .o_alu_result(oalu[2]),
        .o_read_data(ordata[2]), .o_misaligned(omis[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
    endfunction

    // Reference: memory as bytes, size from access code, sign extension by subtraction.
    task automatic model_access(input int d, input logic [31:0] a, input logic [31:0] sd,
                                input logic wr, input logic rd, input logic [1:0] bz, input logic u,
                                output logic [31:0] exp_rd, output logic exp_mis, output int exp_lat);
        int sz, w, off;
        logic [31:0] word;
        longint v;
        sz = (bz == 2'b00) ? 1 : ((bz == 2'b01) ? 2 : 4);
        w = int'((a >> 2) & 32'd31);
        off = int'(a & 32'd3);
        exp_mis = (wr || rd) && ((off % sz) != 0);
        exp_rd = 32'd0;
        exp_lat = 1;
        if (!exp_mis && wr) begin
            word = mdl[d][w];
            for (int i = 0; i < sz; i++) word[8*(off+i) +: 8] = sd[8*i +: 8];
            mdl[d][w] = word;
        end else if (!exp_mis && rd) begin
            v = longint'(mdl[d][w] >> (8*off)) & longint'((64'd1 << (8*sz)) - 64'd1);
            if (!u && sz < 4 && v >= longint'(64'd1 << (8*sz-1))) v = v - longint'(64'd1 << (8*sz));
            exp_rd = v[31:0];
            exp_lat = lat_of(d);
        end
    endtask

    // Upstream behaviour: present op, hold it while o_stall, drop valid after the consuming edge.
    task automatic drive_op(input int d, input logic [31:0] a, input logic [31:0] sd,
                            input logic wr, input logic rd, input logic [1:0] bz, input logic u,
                            output int lat_obs, output int stall_cyc, output int early_vld,
                            output logic vld_obs, output logic [31:0] alu_obs,
                            output logic [31:0] rd_obs, output logic mis_obs);
        logic st;
        @(negedge clk);
        i_addr = a; i_sdata = sd; i_wr = wr; i_rd = rd; i_bz = bz; i_uns = u;
        vld[d] = 1'b1;
        lat_obs = -1; stall_cyc = 0; early_vld = 0;
        vld_obs = 1'b0; alu_obs = 32'd0; rd_obs = 32'd0; mis_obs = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            st = stall[d];
            if (st) stall_cyc++;
            @(posedge clk);
            #1;
            if (!st) begin
                lat_obs = k; vld_obs = ov[d]; alu_obs = oalu[d]; rd_obs = ordata[d]; mis_obs = omis[d];
                break;
            end
            if (ov[d]) early_vld++;
        end
        vld[d] = 1'b0;
    endtask

    task automatic init_memory();
        logic [31:0] sd;
        for (int d = 0; d < ND; d++) begin
            for (int w = 0; w < 32; w++) begin
                sd = $urandom;
                model_access(d, 32'(w * 4), sd, 1'b1, 1'b0, 2'b11, 1'b0, er, em, el);
                drive_op(d, 32'(w * 4), sd, 1'b1, 1'b0, 2'b11, 1'b0, lat_o, stc, ev, vo, ao, ro, mo);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        for (int d = 0; d < ND; d++) begin
            tests_run++;
            if ({ov[d], omis[d], stall[d], oalu[d], ordata[d]} !== 67'd0) begin
                tests_failed++;
                $display("FAIL reset_outputs dut%0d: valid=%b mis=%b stall=%b alu=%h rd=%h, want all 0",
                         d, ov[d], omis[d], stall[d], oalu[d], ordata[d]);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_word_l1();
        model_access(0, 32'h08, 32'hDEADBEEF, 1'b1, 1'b0, 2'b11, 1'b0, er, em, el);
        drive_op(0, 32'h08, 32'hDEADBEEF, 1'b1, 1'b0, 2'b11, 1'b0, lat_o, stc, ev, vo, ao, ro, mo);
        model_access(0, 32'h08, 32'h0, 1'b0, 1'b1, 2'b11, 1'b0, er, em, el);
        drive_op(0, 32'h08, 32'h0, 1'b0, 1'b1, 2'b11, 1'b0, lat_o, stc, ev, vo, ao, ro, mo);
        tests_run++;
        if (ro !== 32'hDEADBEEF || vo !== 1'b1) begin
            tests_failed++;
            $display("FAIL lw_l1_data: rd=%h valid=%b, want DEADBEEF valid=1", ro, vo);
        end
        tests_run++;
        if (lat_o !== 1 || stc !== 0) begin
            tests_failed++;
            $display("FAIL lw_l1_latency: lat=%0d stall_cycles=%0d, want 1 and 0", lat_o, stc);
        end
    endtask

    task automatic test_byte();
        model_access(0, 32'h08, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0, er, em, el);
        drive_op(0, 32'h08, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0, lat_o, stc, ev, vo, ao, ro, mo);
        model_access(0, 32'h09, 32'h80, 1'b1, 1'b0, 2'b00, 1'b0, er, em, el);
        drive_op(0, 32'h09, 32'h80, 1'b1, 1'b0, 2'b00, 1'b0, lat_o, stc, ev, vo, ao, ro, mo);
        dbg_addr = 5'd2;
        #1;
        tests_run++;
        if (dbg_o[0] !== 32'h00008000) begin
            tests_failed++;
            $display("FAIL sb_debug_word: dbg=%h, want 00008000", dbg_o[0]);
        end
        drive_op(0, 32'h09, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0, lat_o, stc, ev, vo, ao, ro, mo);
        tests_run++;
        if (ro !== 32'hFFFFFF80) begin
            tests_failed++;
            $display("FAIL lb_signed: rd=%h, want FFFFFF80", ro);
        end
        drive_op(0, 32'h09, 32'h0, 1'b0, 1'b1, 2'b00, 1'b1, lat_o, stc, ev, vo, ao, ro, mo);
        tests_run++;
        if (ro !== 32'h00000080) begin
            tests_failed++;
            $display("FAIL lbu_unsigned: rd=%h, want 00000080", ro);
        end
    endtask

    task automatic test_misaligned();
        model_access(0, 32'h0A, 32'h1234, 1'b1, 1'b0, 2'b01, 1'b0, er, em, el);
        drive_op(0, 32'h0A, 32'h1234, 1'b1, 1'b0, 2'b01, 1'b0, lat_o, stc, ev, vo, ao, ro, mo);
        drive_op(0, 32'h0B, 32'h0, 1'b0, 1'b1, 2'b01, 1'b0, lat_o, stc, ev, vo, ao, ro, mo);
        tests_run++;
        if (mo !== 1'b1 || ro !== 32'd0 || vo !== 1'b1 || lat_o !== 1) begin
            tests_failed++;
            $display("FAIL lh_misaligned: mis=%b rd=%h valid=%b lat=%0d, want 1 0 1 1", mo, ro, vo, lat_o);
        end
        dbg_addr = 5'd2;
        #1;
        tests_run++;
        if (dbg_o[0] !== 32'h12348000) begin
            tests_failed++;
            $display("FAIL sh_debug_word: dbg=%h, want 12348000", dbg_o[0]);
        end
        drive_op(0, 32'h06, 32'hCAFEF00D, 1'b1, 1'b0, 2'b11, 1'b0, lat_o, stc, ev, vo, ao, ro, mo);
        dbg_addr = 5'd1;
        #1;
        tests_run++;
        if (dbg_o[0] !== mdl[0][1] || mo !== 1'b1) begin
            tests_failed++;
            $display("FAIL sw_misaligned_no_write: dbg=%h mis=%b, want %h mis=1", dbg_o[0], mo, mdl[0][1]);
        end
        drive_op(1, 32'h06, 32'h0, 1'b0, 1'b1, 2'b11, 1'b0, lat_o, stc, ev, vo, ao, ro, mo);
        tests_run++;
        if (mo !== 1'b1 || ro !== 32'd0 || lat_o !== 1 || stc !== 0) begin
            tests_failed++;
            $display("FAIL lw_misaligned_l3: mis=%b rd=%h lat=%0d stall=%0d, want 1 0 1 0", mo, ro, lat_o, stc);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        model_access(1, 32'h40, 32'h5A5AA5A5, 1'b1, 1'b0, 2'b11, 1'b0, er, em, el);
        drive_op(1, 32'h40, 32'h5A5AA5A5, 1'b1, 1'b0, 2'b11, 1'b0, lat_o, stc, ev, vo, ao, ro, mo);
        for (int n = 0; n < 3; n++) begin
            a = (n == 0) ? 32'h40 : 32'($urandom_range(0, 31) * 4);
            model_access(1, a, 32'h0, 1'b0, 1'b1, 2'b11, 1'b0, er, em, el);
            drive_op(1, a, 32'h0, 1'b0, 1'b1, 2'b11, 1'b0, lat_o, stc, ev, vo, ao, ro, mo);
            tests_run++;
            if (lat_o !== 3 || stc !== 2 || ev !== 0 || vo !== 1'b1) begin
                tests_failed++;
                $display("FAIL lw_l3_timing #%0d: lat=%0d stall=%0d early=%0d valid=%b, want 3 2 0 1",
                         n, lat_o, stc, ev, vo);
            end
            tests_run++;
            if (ro !== er || ao !== a) begin
                tests_failed++;
                $display("FAIL lw_l3_data #%0d: rd=%h alu=%h, want %h %h", n, ro, ao, er, a);
            end
        end
    endtask

    task automatic test_reset_wait();
        int seen;
        @(negedge clk);
        i_addr = 32'h10; i_wr = 1'b0; i_rd = 1'b1; i_bz = 2'b11; i_uns = 1'b0;
        vld[2] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        tests_run++;
        if (stall[2] !== 1'b1 || ov[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL l4_in_wait: stall=%b valid=%b, want 1 0", stall[2], ov[2]);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({ov[2], omis[2], oalu[2], ordata[2]} !== 66'd0) begin
            tests_failed++;
            $display("FAIL async_reset_wait: valid=%b mis=%b alu=%h rd=%h, want all 0", ov[2], omis[2], oalu[2], ordata[2]);
        end
        vld[2] = 1'b0;
        #1;
        tests_run++;
        if (stall[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_clears_stall: stall=%b, want 0", stall[2]);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ov[2]) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL aborted_load_valid: valid seen %0d times, want 0", seen);
        end
        model_access(2, 32'h10, 32'h0, 1'b0, 1'b1, 2'b01, 1'b0, er, em, el);
        drive_op(2, 32'h10, 32'h0, 1'b0, 1'b1, 2'b01, 1'b0, lat_o, stc, ev, vo, ao, ro, mo);
        tests_run++;
        if (lat_o !== 4 || stc !== 3 || vo !== 1'b1 || ro !== er) begin
            tests_failed++;
            $display("FAIL l4_after_reset: lat=%0d stall=%0d valid=%b rd=%h, want 4 3 1 %h", lat_o, stc, vo, ro, er);
        end
    endtask

    task automatic test_wrap_passthrough();
        model_access(0, 32'hFC, 32'h0, 1'b0, 1'b0, 2'b11, 1'b0, er, em, el);
        drive_op(0, 32'hFC, 32'h0, 1'b0, 1'b0, 2'b11, 1'b0, lat_o, stc, ev, vo, ao, ro, mo);
        tests_run++;
        if (ao !== 32'hFC || ro !== 32'd0 || mo !== 1'b0 || vo !== 1'b1) begin
            tests_failed++;
            $display("FAIL passthrough: alu=%h rd=%h mis=%b valid=%b, want FC 0 0 1", ao, ro, mo, vo);
        end
        model_access(0, 32'hFC, 32'h13579BDF, 1'b1, 1'b0, 2'b11, 1'b0, er, em, el);
        drive_op(0, 32'hFC, 32'h13579BDF, 1'b1, 1'b0, 2'b11, 1'b0, lat_o, stc, ev, vo, ao, ro, mo);
        dbg_addr = 5'd31;
        #1;
        tests_run++;
        if (dbg_o[0] !== 32'h13579BDF) begin
            tests_failed++;
            $display("FAIL wrap_word31: dbg=%h, want 13579BDF", dbg_o[0]);
        end
        drive_op(0, 32'h7C, 32'h0, 1'b0, 1'b1, 2'b11, 1'b0, lat_o, stc, ev, vo, ao, ro, mo);
        tests_run++;
        if (ro !== 32'h13579BDF) begin
            tests_failed++;
            $display("FAIL wrap_load: rd=%h, want 13579BDF", ro);
        end
    endtask

    task automatic test_idle_hold();
        drive_op(0, 32'h12345678, 32'h0, 1'b0, 1'b0, 2'b11, 1'b0, lat_o, stc, ev, vo, ao, ro, mo);
        @(posedge clk);
        #1;
        tests_run++;
        if (ov[0] !== 1'b0 || oalu[0] !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL idle_hold: valid=%b alu=%h, want 0 12345678", ov[0], oalu[0]);
        end
    endtask

    task automatic test_random();
        int d, kind;
        logic [31:0] a, sd;
        logic wr, rd, u;
        logic [1:0] bz;
        for (int n = 0; n < 150; n++) begin
            d = $urandom_range(0, ND - 1);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            sd = $urandom;
            kind = $urandom_range(0, 3);
            wr = (kind == 0) || (kind == 3);
            rd = (kind == 1) || (kind == 3);
            bz = 2'($urandom_range(0, 3));
            u = 1'($urandom_range(0, 1));
            model_access(d, a, sd, wr, rd, bz, u, er, em, el);
            drive_op(d, a, sd, wr, rd, bz, u, lat_o, stc, ev, vo, ao, ro, mo);
            tests_run++;
            if (lat_o !== el || stc !== el - 1 || ev !== 0 || vo !== 1'b1) begin
                tests_failed++;
                $display("FAIL rnd_timing #%0d dut%0d: lat=%0d stall=%0d early=%0d valid=%b, want %0d %0d 0 1",
                         n, d, lat_o, stc, ev, vo, el, el - 1);
            end
            tests_run++;
            if (ao !== a || ro !== er || mo !== em) begin
                tests_failed++;
                $display("FAIL rnd_result #%0d dut%0d: alu=%h rd=%h mis=%b, want %h %h %b",
                         n, d, ao, ro, mo, a, er, em);
            end
            dbg_addr = 5'($urandom_range(0, 31));
            #1;
            tests_run++;
            if (dbg_o[d] !== mdl[d][dbg_addr]) begin
                tests_failed++;
                $display("FAIL rnd_debug #%0d dut%0d word %0d: dbg=%h, want %h", n, d, dbg_addr, dbg_o[d], mdl[d][dbg_addr]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        vld = '0;
        i_addr = 32'd0; i_sdata = 32'd0; i_wr = 1'b0; i_rd = 1'b0; i_bz = 2'b00; i_uns = 1'b0;
        dbg_addr = 5'd0;
        test_reset();
        init_memory();
        test_word_l1();
        test_byte();
        test_misaligned();
        test_back_to_back();
        test_reset_wait();
        test_wrap_passthrough();
        test_idle_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
